// File: rtl/dm_cache_array_if.sv
// Request/response bundle between the cache controller and dm_cache_array.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready never depends on req_valid. A requester
// that sees req_ready low keeps its request (and its fields) stable until it
// transfers. Every transferred request produces rsp_valid high for exactly
// one cycle, on the cycle after the transfer; there is no response back-pressure.
// Response fields (hit/dirty/tag_out/data_out/valid) hold their last values
// while rsp_valid is low.
//
// Signals
//   req_valid/req_ready        request handshake
//   index/word                 line and word select
//   comp/write                 operation mode
//   tag_in/data_in/valid_in    request payload
//   flush                      start an invalidate-all walk
//   rsp_valid                  one-cycle response strobe
//   hit/dirty/tag_out/data_out/valid  line state seen before the access
//   busy                       invalidate walk in progress
//   state_dbg                  array FSM state, for observation only
interface dm_cache_array_if #(
  parameter int INDEX_W = 4,
  parameter int WORD_W  = 2,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 16
);
  logic               req_valid;
  logic               req_ready;
  logic [INDEX_W-1:0] index;
  logic [WORD_W-1:0]  word;
  logic               comp;
  logic               write;
  logic [TAG_W-1:0]   tag_in;
  logic [DATA_W-1:0]  data_in;
  logic               valid_in;
  logic               flush;
  logic               rsp_valid;
  logic               hit;
  logic               dirty;
  logic [TAG_W-1:0]   tag_out;
  logic [DATA_W-1:0]  data_out;
  logic               valid;
  logic               busy;
  logic [1:0]         state_dbg;

  modport master (
    output req_valid, index, word, comp, write, tag_in, data_in, valid_in, flush,
    input  req_ready, rsp_valid, hit, dirty, tag_out, data_out, valid, busy, state_dbg
  );

  modport slave (
    input  req_valid, index, word, comp, write, tag_in, data_in, valid_in, flush,
    output req_ready, rsp_valid, hit, dirty, tag_out, data_out, valid, busy, state_dbg
  );
endinterface

// File: rtl/dm_cache_array.sv
// Direct-mapped cache storage array: tag, valid, dirty and data words for
// 2^INDEX_W lines of 2^WORD_W words each, with one registered access per cycle
// and a hardware invalidate walk after reset and on flush.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset; restarts the invalidate walk
//   bus   dm_cache_array_if slave modport (request, response, busy, state_dbg)
//
// Operation modes (L = addressed line):
//   compare read   hit = L.valid && L.tag == tag_in, no state change
//   compare write  on hit: word written, L.dirty set; otherwise no change
//   access read    hit = 0, no state change
//   access write   word written, tag <= tag_in, valid <= valid_in, dirty <= 0
// The response always reports the line as it was before the access. Writes
// land in the arrays at the accept edge, so a request in the next cycle reads
// the updated contents directly and no bypass path is needed.
module dm_cache_array #(
  parameter int INDEX_W = 4,
  parameter int WORD_W  = 2,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  dm_cache_array_if.slave   bus
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << WORD_W;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_READY = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;

  logic walk_active;
  logic req_ready_c;

  // Storage. Only valid/dirty are cleared by the walk; tag and data keep
  // whatever they held.
  logic [TAG_W-1:0]  line_tag_q   [LINES];
  logic [LINES-1:0]  line_valid_q;
  logic [LINES-1:0]  line_dirty_q;
  logic [DATA_W-1:0] line_data_q  [LINES*WORDS];

  // Response registers
  logic              rsp_valid_q;
  logic              rsp_hit_q;
  logic              rsp_dirty_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_line_valid_q;

  // Addressed line, as currently stored
  logic [INDEX_W+WORD_W-1:0] word_addr;
  logic                      cur_valid;
  logic                      cur_dirty;
  logic [TAG_W-1:0]          cur_tag;
  logic [DATA_W-1:0]         cur_data;
  logic                      line_hit;

  logic accept;
  logic do_fill;
  logic do_cwrite;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT, S_FLUSH: begin
        // One line cleared per cycle; the counter wraps back to zero as the
        // last line is cleared, so it is ready for the next walk.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {INDEX_W{1'b1}}) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (bus.flush) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    walk_active = (state_q == S_INIT) || (state_q == S_FLUSH);
    // flush wins over a same-cycle request: the request is simply not accepted.
    req_ready_c = (state_q == S_READY) && !bus.flush;
  end

  assign bus.busy      = walk_active;
  assign bus.req_ready = req_ready_c;
  assign bus.state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // Line lookup and write enables
  // ---------------------------------------------------------------------------
  assign word_addr = {bus.index, bus.word};
  assign cur_valid = line_valid_q[bus.index];
  assign cur_dirty = line_dirty_q[bus.index];
  assign cur_tag   = line_tag_q[bus.index];
  assign cur_data  = line_data_q[word_addr];
  assign line_hit  = cur_valid && (cur_tag == bus.tag_in);

  // rst gating keeps an access from landing on the same edge that restarts
  // the array.
  assign accept    = bus.req_valid && req_ready_c && !rst;
  assign do_fill   = accept && bus.write && !bus.comp;
  assign do_cwrite = accept && bus.write && bus.comp && line_hit;

  // ---------------------------------------------------------------------------
  // Valid / dirty storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (walk_active) begin
      line_valid_q[cnt_q] <= 1'b0;
      line_dirty_q[cnt_q] <= 1'b0;
    end else if (do_fill) begin
      line_valid_q[bus.index] <= bus.valid_in;
      line_dirty_q[bus.index] <= 1'b0;
    end else if (do_cwrite) begin
      line_dirty_q[bus.index] <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag / data storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (do_fill) begin
      line_tag_q[bus.index] <= bus.tag_in;
    end
    if (do_fill || do_cwrite) begin
      line_data_q[word_addr] <= bus.data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers: capture pre-access line state on accept, hold otherwise
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q      <= 1'b0;
      rsp_hit_q        <= 1'b0;
      rsp_dirty_q      <= 1'b0;
      rsp_tag_q        <= '0;
      rsp_data_q       <= '0;
      rsp_line_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_hit_q        <= bus.comp && line_hit;
        rsp_dirty_q      <= cur_dirty;
        rsp_tag_q        <= cur_tag;
        rsp_data_q       <= cur_data;
        rsp_line_valid_q <= cur_valid;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.hit       = rsp_hit_q;
  assign bus.dirty     = rsp_dirty_q;
  assign bus.tag_out   = rsp_tag_q;
  assign bus.data_out  = rsp_data_q;
  assign bus.valid     = rsp_line_valid_q;

endmodule

// File: tb/tb_dm_cache_array.sv
// Self-checking bench for dm_cache_array: directed steps followed by random
// traffic, all checked against a line/word array model of the cache.
module tb_dm_cache_array;

  localparam int INDEX_W = 4;
  localparam int WORD_W  = 2;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 16;
  localparam int LINES   = 1 << INDEX_W;
  localparam int WORDS   = 1 << WORD_W;
  localparam int EW      = 26;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_cache_array_if #(
    .INDEX_W(INDEX_W), .WORD_W(WORD_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) bus ();

  dm_cache_array #(
    .INDEX_W(INDEX_W), .WORD_W(WORD_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: the cache as plain arrays plus a walk countdown.
  // Known flags mark tag/data that were ever written (the walk leaves them alone).
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0]  m_tag   [LINES];
  bit                m_tk    [LINES];
  bit                m_valid [LINES];
  bit                m_dirty [LINES];
  logic [DATA_W-1:0] m_data  [LINES*WORDS];
  bit                m_dk    [LINES*WORDS];
  int                walk_left;
  bit                pend;

  // Expected response entry: {tag_known, data_known, hit, dirty, valid, tag, data}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_rsp;

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_fields(input string pfx, input logic [EW-1:0] e);
    chk({pfx, "_hit"},   32'(bus.hit),   32'(e[23]));
    chk({pfx, "_dirty"}, 32'(bus.dirty), 32'(e[22]));
    chk({pfx, "_valid"}, 32'(bus.valid), 32'(e[21]));
    if (e[25]) chk({pfx, "_tag"},  32'(bus.tag_out),  32'(e[20:16]));
    if (e[24]) chk({pfx, "_data"}, 32'(bus.data_out), 32'(e[15:0]));
  endtask

  task automatic model_reset_walk();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle. Checks the response to the previous cycle's
  // request, drives this cycle's inputs, then advances the model across the
  // coming rising edge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input bit rv, input bit c, input bit w,
                     input logic [INDEX_W-1:0] ix, input logic [WORD_W-1:0] wd,
                     input logic [TAG_W-1:0] tg, input logic [DATA_W-1:0] d,
                     input bit vi, input bit fl);
    logic [EW-1:0] e;
    bit exp_ready;
    bit h;
    int a;
    @(negedge clk);
    if (pend) begin
      chk("rsp_valid_pulse", 32'(bus.rsp_valid), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_fields("rsp", e);
        last_rsp = e;
      end
    end else begin
      chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
      chk_fields("hold", last_rsp);
    end
    chk("busy", 32'(bus.busy), 32'(walk_left != 0));

    bus.req_valid = rv;
    bus.comp      = c;
    bus.write     = w;
    bus.index     = ix;
    bus.word      = wd;
    bus.tag_in    = tg;
    bus.data_in   = d;
    bus.valid_in  = vi;
    bus.flush     = fl;
    #1;
    exp_ready = (walk_left == 0) && !fl;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));

    pend = rv && exp_ready;
    if (walk_left != 0) begin
      walk_left--;
    end else if (fl) begin
      walk_left = LINES;
      model_reset_walk();
    end

    if (pend) begin
      a = int'(ix) * WORDS + int'(wd);
      h = c && m_valid[ix] && (m_tag[ix] == tg);
      e = {m_tk[ix], m_dk[a], h, m_dirty[ix], m_valid[ix], m_tag[ix], m_data[a]};
      exp_q.push_back(e);
      if (w && !c) begin
        m_data[a]   = d;
        m_dk[a]     = 1'b1;
        m_tag[ix]   = tg;
        m_tk[ix]    = 1'b1;
        m_valid[ix] = vi;
        m_dirty[ix] = 1'b0;
      end else if (w && c && h) begin
        m_data[a]   = d;
        m_dirty[ix] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, '0, '0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < LINES; i++) begin
      m_tag[i] = '0;
      m_tk[i]  = 1'b0;
    end
    for (int i = 0; i < LINES*WORDS; i++) begin
      m_data[i] = '0;
      m_dk[i]   = 1'b0;
    end
    model_reset_walk();
    pend      = 1'b0;
    last_rsp  = '0;
    last_rsp[25:24] = 2'b11;

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.comp      = 1'b0;
    bus.write     = 1'b0;
    bus.index     = '0;
    bus.word      = '0;
    bus.tag_in    = '0;
    bus.data_in   = '0;
    bus.valid_in  = 1'b0;
    bus.flush     = 1'b0;

    // Power-on reset, released; the first walk edge follows the release.
    repeat (2) @(negedge clk);
    chk("reset_busy",      32'(bus.busy),      32'd1);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_data_out",  32'(bus.data_out),  32'd0);
    chk("reset_tag_out",   32'(bus.tag_out),   32'd0);
    rst       = 1'b0;
    walk_left = LINES - 1;
    idle(5);

    // Reset again mid-walk for 3 cycles; a request offered meanwhile is ignored.
    rst           = 1'b1;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_busy",      32'(bus.busy),      32'd1);
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_hit",       32'(bus.hit),       32'd0);
      chk("midrst_valid",     32'(bus.valid),     32'd0);
      chk("midrst_dirty",     32'(bus.dirty),     32'd0);
    end
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    walk_left     = LINES - 1;
    idle(LINES);

    // Every line reads invalid after the walk.
    for (int i = 0; i < LINES; i++) cyc(1, 1, 0, INDEX_W'(i), '0, 5'h15, '0, 0, 0);

    // Give every word a known value; lines stay invalid.
    for (int i = 0; i < LINES*WORDS; i++)
      cyc(1, 0, 1, INDEX_W'(i / WORDS), WORD_W'(i % WORDS), TAG_W'($urandom_range(0, 31)),
          DATA_W'($urandom), 0, 0);

    // Fill, then compare-read hit.
    cyc(1, 0, 1, 4'd3, 2'd2, 5'h15, 16'hBEEF, 1, 0);
    cyc(1, 1, 0, 4'd3, 2'd2, 5'h15, 16'h0000, 0, 0);
    // Compare write hit, then read back dirty and the new word.
    cyc(1, 1, 1, 4'd3, 2'd1, 5'h15, 16'h1234, 0, 0);
    cyc(1, 1, 0, 4'd3, 2'd1, 5'h15, 16'h0000, 0, 0);
    // Compare write miss on tag leaves the line unchanged.
    cyc(1, 1, 1, 4'd3, 2'd1, 5'h0A, 16'h5555, 0, 0);
    cyc(1, 1, 0, 4'd3, 2'd1, 5'h15, 16'h0000, 0, 0);
    // Invalid line with a matching tag never hits.
    cyc(1, 0, 1, 4'd7, 2'd0, 5'h09, 16'hA5A5, 0, 0);
    cyc(1, 1, 0, 4'd7, 2'd0, 5'h09, 16'h0000, 0, 0);
    // Back-to-back write/read on line 5; access read never hits.
    cyc(1, 0, 1, 4'd5, 2'd3, 5'h02, 16'hCAFE, 1, 0);
    cyc(1, 0, 0, 4'd5, 2'd3, 5'h02, 16'h0000, 0, 0);
    cyc(1, 1, 0, 4'd5, 2'd3, 5'h02, 16'h0000, 0, 0);
    idle(2);

    // flush with a same-cycle request: request dropped, walk runs, flush ignored mid-walk.
    cyc(1, 1, 1, 4'd3, 2'd2, 5'h15, 16'h7777, 0, 1);
    idle(4);
    cyc(1, 1, 0, 4'd3, 2'd2, 5'h15, 16'h0000, 0, 1);
    idle(LINES - 5);
    cyc(1, 1, 0, 4'd3, 2'd2, 5'h15, 16'h0000, 0, 0);
    cyc(1, 1, 0, 4'd5, 2'd3, 5'h02, 16'h0000, 0, 0);
    idle(1);

    // Random traffic over a small tag set so hits and misses both occur.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 9) < 8), 1'($urandom), 1'($urandom),
          INDEX_W'($urandom_range(0, LINES-1)), WORD_W'($urandom_range(0, WORDS-1)),
          TAG_W'($urandom_range(0, 3)), DATA_W'($urandom), 1'($urandom_range(0, 3) != 0),
          ($urandom_range(0, 79) == 0));
    end
    idle(2);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
